// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: FU result packet, broadcast packet and the round-robin step helper.
// Used by cdb_arbiter and its rr_arbiter.
package cdb_arbiter_pkg;

    localparam int NUM_FU_DEFAULT = 4;
    localparam int ROB_TAG_W      = 6;
    localparam int DATA_W         = 32;

    typedef logic [ROB_TAG_W-1:0] ROB_TAG;
    typedef logic [DATA_W-1:0]    DATA;

    typedef struct packed {
        ROB_TAG rob_tag;
        DATA    value;
    } FU_CDB_PACKET;

    // rob_tag 0 is never allocated, so an all-zero packet is a safe idle bus.
    typedef struct packed {
        logic   valid;
        ROB_TAG rob_tag;
        DATA    value;
    } CDB_PACKET;

    function automatic int rr_next_idx(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester found scanning from ptr upward, modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] winner,
    output logic                 any
);

    localparam int W = $clog2(N);

    logic [W-1:0] idx;

    always_comb begin
        gnt    = '0;
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = W'((int'(ptr) + i) % N);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                winner   = idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin owner of the common data bus; registers the winning FU result as the broadcast.
// Optional per-FU grant and conflict counters are built when CDB_PERF_CNT_EN is defined.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = NUM_FU_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  logic [NUM_FU-1:0]          fu_req,
    input  FU_CDB_PACKET [NUM_FU-1:0]  fu_data,
    output logic [NUM_FU-1:0]          fu_grant,
    output CDB_PACKET                  cdb_packet
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [32*NUM_FU-1:0]       grant_cnt,
    output logic [31:0]                conflict_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_FU);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  winner;
    logic [NUM_FU-1:0] req_eligible;
    logic              grant_any;
    CDB_PACKET         cdb_packet_q, cdb_packet_d;

    // Squash and reset hide every request, so no FU sees its result consumed.
    assign req_eligible = (reset || squash) ? '0 : fu_req;

    rr_arbiter #(.N(NUM_FU)) u_rr (
        .req    (req_eligible),
        .ptr    (rr_ptr_q),
        .gnt    (fu_grant),
        .winner (winner),
        .any    (grant_any)
    );

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        cdb_packet_d = '0;
        if (grant_any) begin
            rr_ptr_d             = PTR_W'(rr_next_idx(int'(winner), NUM_FU));
            cdb_packet_d.valid   = 1'b1;
            cdb_packet_d.rob_tag = fu_data[winner].rob_tag;
            cdb_packet_d.value   = fu_data[winner].value;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            cdb_packet_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            cdb_packet_q <= cdb_packet_d;
        end
    end

    assign cdb_packet = cdb_packet_q;

`ifdef CDB_PERF_CNT_EN
    logic [NUM_FU-1:0][31:0] grant_cnt_q;
    logic [31:0]             conflict_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            for (int n = 0; n < NUM_FU; n++) begin
                if (fu_grant[n] && (grant_cnt_q[n] != '1))
                    grant_cnt_q[n] <= grant_cnt_q[n] + 32'd1;
            end
            if (!squash && ($countones(fu_req) > 1) && (conflict_cnt_q != '1))
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign grant_cnt    = grant_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

    // A requesting FU must carry an allocated tag; the bus never grants twice.
    always @(posedge clock) begin
        if (!reset) begin
            for (int n = 0; n < NUM_FU; n++)
                assert (!(fu_req[n] && (fu_data[n].rob_tag == '0)));
            assert ($onehot0(fu_grant));
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter; counter checks compile in with CDB_PERF_CNT_EN.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NFU   = 4;
    localparam int PKT_W = $bits(CDB_PACKET);

    logic                  clock;
    logic                  reset;
    logic                  squash;
    logic [NFU-1:0]        fu_req;
    FU_CDB_PACKET [NFU-1:0] fu_data;
    logic [NFU-1:0]        fu_grant;
    CDB_PACKET             cdb_packet;
`ifdef CDB_PERF_CNT_EN
    logic [32*NFU-1:0]     grant_cnt;
    logic [31:0]           conflict_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [PKT_W-1:0] exp_q[$];

    cdb_arbiter #(.NUM_FU(NFU)) dut (
        .clock        (clock),
        .reset        (reset),
        .squash       (squash),
        .fu_req       (fu_req),
        .fu_data      (fu_data),
        .fu_grant     (fu_grant),
        .cdb_packet   (cdb_packet)
`ifdef CDB_PERF_CNT_EN
        ,
        .grant_cnt    (grant_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pkt();
        logic [PKT_W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cdb_packet", 64'(cdb_packet), 64'(e));
        end else begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_underflow: observed empty expected entry");
        end
    endtask

    // One bus cycle: check last cycle's broadcast and the current pointer,
    // drive new inputs, check the same-cycle grant, queue the next broadcast.
    task automatic step(input logic [NFU-1:0] req, input logic sq, input logic rst,
                        input logic [NFU-1:0] exp_gnt, input int exp_ptr);
        CDB_PACKET e;
        @(negedge clock);
        check_pkt();
        check("rr_ptr", 64'(dut.rr_ptr_q), 64'(exp_ptr));
        fu_req = req;
        squash = sq;
        reset  = rst;
        #1;
        check("fu_grant", 64'(fu_grant), 64'(exp_gnt));
        e = '0;
        if (!rst) begin
            for (int n = 0; n < NFU; n++) begin
                if (exp_gnt[n]) begin
                    e.valid   = 1'b1;
                    e.rob_tag = fu_data[n].rob_tag;
                    e.value   = fu_data[n].value;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    initial begin
        reset  = 1'b1;
        squash = 1'b0;
        fu_req = '0;
        for (int n = 0; n < NFU; n++) begin
            fu_data[n].rob_tag = ROB_TAG'($urandom_range(1, 63));
            fu_data[n].value   = DATA'($urandom_range(0, 32'h7fff_ffff));
        end
        fu_data[2].rob_tag = ROB_TAG'(5);
        fu_data[2].value   = DATA'(32'hAB);
        repeat (2) @(posedge clock);
        exp_q.push_back('0);

        // Idle after reset
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 0);
        // Sole requester FU2, then FU3 from ptr 3
        step(4'b0100, 1'b0, 1'b0, 4'b0100, 0);
        step(4'b1000, 1'b0, 1'b0, 4'b1000, 3);
        // Reset, then 8 cycles of full contention
        step(4'b0000, 1'b0, 1'b1, 4'b0000, 0);
        step(4'b1111, 1'b0, 1'b0, 4'b0001, 0);
        step(4'b1111, 1'b0, 1'b0, 4'b0010, 1);
        step(4'b1111, 1'b0, 1'b0, 4'b0100, 2);
        step(4'b1111, 1'b0, 1'b0, 4'b1000, 3);
        step(4'b1111, 1'b0, 1'b0, 4'b0001, 0);
        step(4'b1111, 1'b0, 1'b0, 4'b0010, 1);
        step(4'b1111, 1'b0, 1'b0, 4'b0100, 2);
        step(4'b1111, 1'b0, 1'b0, 4'b1000, 3);
        step(4'b1111, 1'b0, 1'b0, 4'b0001, 0);
`ifdef CDB_PERF_CNT_EN
        for (int n = 0; n < NFU; n++)
            check($sformatf("grant_cnt[%0d]", n), 64'(grant_cnt[n*32 +: 32]), 64'd2);
        check("conflict_cnt", 64'(conflict_cnt), 64'd8);
`endif
        // Reset mid-stream with all FUs requesting
        step(4'b1111, 1'b0, 1'b0, 4'b0010, 1);
        step(4'b1111, 1'b0, 1'b1, 4'b0000, 2);
        step(4'b1111, 1'b0, 1'b0, 4'b0001, 0);
`ifdef CDB_PERF_CNT_EN
        check("conflict_cnt_after_reset", 64'(conflict_cnt), 64'd0);
`endif
        // Bring ptr to 2, then FU1 and FU3 compete
        step(4'b0010, 1'b0, 1'b0, 4'b0010, 1);
        step(4'b1010, 1'b0, 1'b0, 4'b1000, 2);
        step(4'b0010, 1'b0, 1'b0, 4'b0010, 0);
        // Squash drops FU1's grant; it is granted the next cycle
        step(4'b0010, 1'b1, 1'b0, 4'b0000, 2);
        step(4'b0010, 1'b0, 1'b0, 4'b0010, 2);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2);

        @(negedge clock);
        check_pkt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
